rv32i_mc_top: RTL and testbench

- Self-contained RV32I multi-cycle processor top with clk/rst as its only ports.
- Contains the core, an instruction memory instance IM1 and a data memory instance DM1, each wrapping a synchronous SRAM.
- Program and data are preloaded through hierarchical writes into the SRAM arrays.
- Completion is signalled by software writing 0xFFFFFFFF to the last DM word.

---
 rtl/rv32_pkg.sv | 59 +++++
 rtl/SRAM_wrapper.sv | 38 +++
 rtl/rv32_alu.sv | 35 +++
 rtl/rv32i_mc_top.sv | 213 +++++++++++++++++++++
 tb/tb_rv32i_mc_top.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared encodings for the RV32I multi-cycle core: opcodes, funct3 codes,
// ALU operations, FSM states and the read-only counter CSR addresses.
package rv32_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] F3_PRIV = 3'b000;
  localparam logic [2:0] F3_SRX  = 3'b101;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {S_IF, S_EX, S_WB} state_e;

  // alt is instr[30], already qualified by the caller so ADDI never subtracts
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/SRAM_wrapper.sv
// Library synchronous SRAM (512x32 words of 32 bits) with active-low controls
// and a registered read port; contents are never reset.
module SRAM (
  input  logic        CK,
  input  logic        CEB,
  input  logic        WEB,
  input  logic [31:0] BWEB,
  input  logic [13:0] A,
  input  logic [31:0] DI,
  output logic [31:0] DO
);

  logic [31:0] MEMORY [512][32];

  always_ff @(posedge CK) begin
    if (!CEB) begin
      if (!WEB)
        MEMORY[A[13:5]][A[4:0]] <= (MEMORY[A[13:5]][A[4:0]] & BWEB) | (DI & ~BWEB);
      else
        DO <= MEMORY[A[13:5]][A[4:0]];
    end
  end

endmodule

module SRAM_wrapper (
  input  logic        CK,
  input  logic        CEB,
  input  logic        WEB,
  input  logic [31:0] BWEB,
  input  logic [13:0] A,
  input  logic [31:0] DI,
  output logic [31:0] DO
);

  SRAM i_SRAM (.CK(CK), .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO));

endmodule

// File: rtl/rv32_alu.sv
// Combinational RV32I ALU with the compare flags used for branch resolution.
module rv32_alu
  import rv32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  always_comb begin
    result = 32'h0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'h0, lt};
      ALU_SLTU: result = {31'h0, ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_top.sv
// RV32I multi-cycle core (IF/EX/WB) with private instruction and data SRAMs.
// Software signals completion by writing all-ones to the last data word.
module rv32i_mc_top
  import rv32_pkg::*;
#(
  parameter int          MEM_WORDS = 16384,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);

  localparam int AW = $clog2(MEM_WORDS);

  state_e      state;
  logic [31:0] pc;
  logic [31:0] rf [32];
  logic [63:0] cycle, instret;
  logic [2:0]  ld_f3;
  logic [4:0]  ld_rd;
  logic [1:0]  ld_off;

  logic          im_ceb, dm_ceb, dm_web;
  logic [31:0]   im_do, dm_do, dm_bweb, dm_di;
  logic [AW-1:0] im_a, dm_a;

  // ---------------- decode ----------------
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1v, rs2v, imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr  = im_do;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rs1v   = rf[rs1];
  assign rs2v   = rf[rs2];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'h0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic is_load, is_store;
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);

  // ---------------- execute ----------------
  logic [31:0] alu_a, alu_b, alu_res;
  alu_op_e     alu_op;
  logic        alu_eq, alu_lt, alu_ltu;

  always_comb begin
    alu_a  = rs1v;
    alu_b  = imm_i;
    alu_op = ALU_ADD;
    case (opcode)
      OP_OP:     begin alu_b = rs2v; alu_op = alu_decode(f3, instr[30]); end
      OP_IMM:    alu_op = alu_decode(f3, (f3 == F3_SRX) && instr[30]);
      OP_STORE:  alu_b = imm_s;
      OP_AUIPC:  begin alu_a = pc; alu_b = imm_u; end
      OP_BRANCH: alu_b = rs2v;
      default:   ;
    endcase
  end

  rv32_alu u_alu (
    .a(alu_a), .b(alu_b), .op(alu_op),
    .result(alu_res), .eq(alu_eq), .lt(alu_lt), .ltu(alu_ltu)
  );

  logic taken;
  always_comb begin
    case (f3)
      F3_BEQ:  taken = alu_eq;
      F3_BNE:  taken = !alu_eq;
      F3_BLT:  taken = alu_lt;
      F3_BGE:  taken = !alu_lt;
      F3_BLTU: taken = alu_ltu;
      F3_BGEU: taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  logic [31:0] csr_val;
  always_comb begin
    case (instr[31:20])
      CSR_CYCLE:    csr_val = cycle[31:0];
      CSR_CYCLEH:   csr_val = cycle[63:32];
      CSR_INSTRET:  csr_val = instret[31:0];
      CSR_INSTRETH: csr_val = instret[63:32];
      default:      csr_val = 32'h0;
    endcase
  end

  logic [31:0] pc_plus4, next_pc, rd_val;
  logic        rd_we;
  assign pc_plus4 = pc + 32'd4;

  // FENCE, ECALL/EBREAK and unknown opcodes fall through as PC += 4, no write
  always_comb begin
    rd_we   = 1'b0;
    rd_val  = alu_res;
    next_pc = pc_plus4;
    case (opcode)
      OP_LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC,
      OP_OP,
      OP_IMM:    rd_we = 1'b1;
      OP_JAL:    begin rd_we = 1'b1; rd_val = pc_plus4; next_pc = pc + imm_j; end
      OP_JALR:   begin rd_we = 1'b1; rd_val = pc_plus4; next_pc = alu_res & ~32'h1; end
      OP_BRANCH: if (taken) next_pc = pc + imm_b;
      OP_SYSTEM: if (f3 != F3_PRIV && f3 != 3'b100) begin rd_we = 1'b1; rd_val = csr_val; end
      default:   ;
    endcase
  end

  // ---------------- memory ports ----------------
  always_comb begin
    dm_bweb = 32'hFFFF_FFFF;
    dm_di   = rs2v;
    if (is_store) begin
      case (f3)
        F3_B: begin
          dm_bweb = ~(32'h0000_00FF << {alu_res[1:0], 3'b000});
          dm_di   = rs2v << {alu_res[1:0], 3'b000};
        end
        F3_H: begin
          dm_bweb = ~(32'h0000_FFFF << {alu_res[1], 4'b0000});
          dm_di   = rs2v << {alu_res[1], 4'b0000};
        end
        F3_W:    dm_bweb = 32'h0;
        default: dm_bweb = 32'hFFFF_FFFF;
      endcase
    end
  end

  assign im_ceb = rst || (state != S_IF);
  assign im_a   = pc[AW+1:2];
  assign dm_ceb = rst || !(state == S_EX && (is_load || is_store));
  assign dm_web = !is_store;
  assign dm_a   = alu_res[AW+1:2];

  SRAM_wrapper IM1 (
    .CK(clk), .CEB(im_ceb), .WEB(1'b1), .BWEB(32'hFFFF_FFFF),
    .A(im_a), .DI(32'h0), .DO(im_do)
  );

  SRAM_wrapper DM1 (
    .CK(clk), .CEB(dm_ceb), .WEB(dm_web), .BWEB(dm_bweb),
    .A(dm_a), .DI(dm_di), .DO(dm_do)
  );

  // ---------------- load writeback ----------------
  logic [31:0] ld_sh, ld_val;
  logic [15:0] ld_half;
  assign ld_sh   = dm_do >> {ld_off, 3'b000};
  assign ld_half = ld_off[1] ? dm_do[31:16] : dm_do[15:0];

  always_comb begin
    case (ld_f3)
      F3_B:    ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_H:    ld_val = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_val = {24'h0, ld_sh[7:0]};
      F3_HU:   ld_val = {16'h0, ld_half};
      default: ld_val = dm_do;
    endcase
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IF;
      pc      <= RESET_PC;
      cycle   <= 64'h0;
      instret <= 64'h0;
      ld_f3   <= 3'h0;
      ld_rd   <= 5'h0;
      ld_off  <= 2'h0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else begin
      cycle <= cycle + 64'd1;
      case (state)
        S_IF: state <= S_EX;
        S_EX: begin
          if (is_load) begin
            ld_f3  <= f3;
            ld_rd  <= rd;
            ld_off <= alu_res[1:0];
            state  <= S_WB;
          end else begin
            if (rd_we && rd != 5'd0) rf[rd] <= rd_val;
            pc      <= next_pc;
            instret <= instret + 64'd1;
            state   <= S_IF;
          end
        end
        S_WB: begin
          if (ld_rd != 5'd0) rf[ld_rd] <= ld_val;
          pc      <= pc_plus4;
          instret <= instret + 64'd1;
          state   <= S_IF;
        end
        default: state <= S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mc_top.sv
// Directed program bench for rv32i_mc_top: preloads IM/DM, runs to the end
// flag, then checks the result words the program stored.
module tb_rv32i_mc_top;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   p = 0;
  int   jal_idx, jalr_idx;

  always #5 clk = ~clk;

  rv32i_mc_top dut (.clk(clk), .rst(rst));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OP_OP};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), OP_JAL};
  endfunction

  task automatic emit(input logic [31:0] w);
    logic [13:0] a;
    a = 14'(p);
    dut.IM1.i_SRAM.MEMORY[a[13:5]][a[4:0]] = w;
    p++;
  endtask

  task automatic dm_wr(input int w, input logic [31:0] d);
    logic [13:0] a;
    a = 14'(w);
    dut.DM1.i_SRAM.MEMORY[a[13:5]][a[4:0]] = d;
  endtask

  function automatic logic [31:0] dm(input int w);
    logic [13:0] a;
    a = 14'(w);
    return dut.DM1.i_SRAM.MEMORY[a[13:5]][a[4:0]];
  endfunction

  initial begin
    logic [31:0] ir, cy;
    for (int i = 0; i < 256; i++) emit(enc_i(0, 0, 0, 0, OP_IMM));
    p = 0;
    for (int i = 0; i < 40; i++) dm_wr(i, 32'hDEAD_BEEF);
    dm_wr(4, 32'h8080_7F01);
    dm_wr(16'h3FFF, 32'h0);

    emit(enc_i(12'hC00, 0, 2, 20, OP_SYSTEM));   // csrrs x20, cycle
    emit(enc_i(5, 0, 0, 1, OP_IMM));
    emit(enc_i(-3, 0, 0, 2, OP_IMM));
    emit(enc_r(0, 2, 1, 0, 3));                   // add x3,x1,x2
    emit(enc_r(0, 1, 2, 3, 4));                   // sltu x4,x2,x1
    emit(enc_u(32'h10, 10, OP_LUI));
    emit(enc_s(0, 3, 10, 2));
    emit(enc_s(4, 4, 10, 2));
    emit(enc_s(8, 20, 10, 2));
    emit(enc_s(12, 5, 10, 2));                    // untouched x5
    emit(32'h0000_0073);                          // ecall as NOP
    emit(32'h0000_000F);                          // fence as NOP
    emit(enc_i(16, 10, 0, 11, OP_LOAD)); emit(enc_s(32, 11, 10, 2));
    emit(enc_i(17, 10, 0, 11, OP_LOAD)); emit(enc_s(36, 11, 10, 2));
    emit(enc_i(19, 10, 0, 11, OP_LOAD)); emit(enc_s(40, 11, 10, 2));
    emit(enc_i(18, 10, 1, 11, OP_LOAD)); emit(enc_s(44, 11, 10, 2));
    emit(enc_i(18, 10, 5, 11, OP_LOAD)); emit(enc_s(48, 11, 10, 2));
    emit(enc_i(16, 10, 2, 11, OP_LOAD)); emit(enc_s(52, 11, 10, 2));
    emit(enc_s(56, 0, 10, 2));
    emit(enc_i(12'hAB, 0, 0, 12, OP_IMM));
    emit(enc_s(58, 12, 10, 0));                   // sb at +2
    emit(enc_i(56, 10, 2, 14, OP_LOAD)); emit(enc_s(60, 14, 10, 2));
    emit(enc_u(1, 13, OP_LUI));
    emit(enc_i(12'h234, 13, 0, 13, OP_IMM));
    emit(enc_s(56, 13, 10, 1));                   // sh at +0
    emit(enc_i(10, 0, 0, 15, OP_IMM));
    emit(enc_i(0, 0, 0, 16, OP_IMM));
    emit(enc_i(1, 16, 0, 16, OP_IMM));
    emit(enc_i(-1, 15, 0, 15, OP_IMM));
    emit(enc_b(-8, 0, 15, 1));                    // bne loop
    emit(enc_s(64, 16, 10, 2));
    jal_idx = p;
    emit(enc_j(8, 17));
    emit(enc_i(99, 0, 0, 18, OP_IMM));
    emit(enc_s(68, 17, 10, 2));
    emit(enc_s(72, 18, 10, 2));
    emit(enc_u(0, 19, OP_AUIPC));
    emit(enc_i(17, 19, 0, 19, OP_IMM));           // odd target
    jalr_idx = p;
    emit(enc_i(0, 19, 0, 21, OP_JALR));
    emit(enc_i(1, 0, 0, 22, OP_IMM));
    emit(enc_s(76, 21, 10, 2));
    emit(enc_s(80, 22, 10, 2));
    emit(enc_i(7, 0, 0, 0, OP_IMM));
    emit(enc_s(84, 0, 10, 2));
    emit(enc_i(-1, 0, 0, 23, OP_IMM));
    emit(enc_b(8, 0, 23, 4));                     // blt taken
    emit(enc_i(5, 0, 0, 24, OP_IMM));
    emit(enc_b(8, 0, 23, 6));                     // bltu not taken
    emit(enc_i(3, 0, 0, 25, OP_IMM));
    emit(enc_s(88, 24, 10, 2));
    emit(enc_s(92, 25, 10, 2));
    emit(enc_i(12'h404, 11, 5, 26, OP_IMM));      // srai 4
    emit(enc_s(96, 26, 10, 2));
    emit(enc_i(4, 11, 5, 26, OP_IMM));            // srli 4
    emit(enc_s(100, 26, 10, 2));
    emit(enc_i(12'hC02, 0, 2, 27, OP_SYSTEM));
    emit(enc_i(12'hC00, 0, 2, 28, OP_SYSTEM));
    emit(enc_i(12'hC80, 0, 2, 29, OP_SYSTEM));
    emit(enc_s(104, 27, 10, 2));
    emit(enc_s(108, 28, 10, 2));
    emit(enc_s(112, 29, 10, 2));
    emit(enc_u(32'h20, 30, OP_LUI));
    emit(enc_i(-1, 0, 0, 31, OP_IMM));
    emit(enc_s(-4, 31, 30, 2));
    emit(enc_j(0, 0));                            // spin

    @(posedge clk);
    #1;
    chk("rst_pc", dut.pc, 32'h0);
    chk("rst_im_ceb", {31'h0, dut.im_ceb}, 32'h1);
    chk("rst_dm_ceb", {31'h0, dut.dm_ceb}, 32'h1);
    chk("rst_cycle", dut.cycle[31:0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_im_ceb", {31'h0, dut.im_ceb}, 32'h0);
    chk("first_im_a", {18'h0, dut.im_a}, 32'h0);

    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (dm(16'h3FFF) === 32'hFFFF_FFFF) break;
    end
    chk("end_flag", dm(16'h3FFF), 32'hFFFF_FFFF);

    chk("add", dm(0), 32'h0000_0002);
    chk("sltu", dm(1), 32'h0000_0000);
    chk("first_cycle", dm(2), 32'h0000_0001);
    chk("reg_reset", dm(3), 32'h0000_0000);
    chk("lb0", dm(8), 32'h0000_0001);
    chk("lb1", dm(9), 32'h0000_007F);
    chk("lb3", dm(10), 32'hFFFF_FF80);
    chk("lh2", dm(11), 32'hFFFF_8080);
    chk("lhu2", dm(12), 32'h0000_8080);
    chk("lw", dm(13), 32'h8080_7F01);
    chk("sb2", dm(15), 32'h00AB_0000);
    chk("sh0", dm(14), 32'h00AB_1234);
    chk("loop", dm(16), 32'd10);
    chk("jal_link", dm(17), 32'(4 * jal_idx + 4));
    chk("jal_skip", dm(18), 32'h0);
    chk("jalr_link", dm(19), 32'(4 * jalr_idx + 4));
    chk("jalr_skip", dm(20), 32'h0);
    chk("x0", dm(21), 32'h0);
    chk("blt_taken", dm(22), 32'h0);
    chk("bltu_not", dm(23), 32'd3);
    chk("srai", dm(24), 32'hF808_07F0);
    chk("srli", dm(25), 32'h0808_07F0);
    chk("cycleh", dm(28), 32'h0);
    ir = dm(26);
    cy = dm(27);
    chk("instret_nz", {31'h0, ir != 32'h0}, 32'h1);
    chk("cycle_nz", {31'h0, cy != 32'h0}, 32'h1);
    chk("cycle_gt_instret", {31'h0, cy > ir}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
